// File: rtl/rf_pkg.sv
// Shared constants and types for the scoreboarded integer register file.
package rf_pkg;
  localparam int XLEN         = 32;
  localparam int NUM_REGS     = 32;
  localparam int NUM_RD_PORTS = 2;
  localparam int REG_AW       = $clog2(NUM_REGS);
  localparam int REG_X0       = 0;
  localparam int REG_SP       = 2;
  localparam int DBG_REG_IDX  = 17;
  localparam logic [XLEN-1:0] SP_INIT_VAL = 32'h2ffc;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xword_t;
endpackage

// File: rtl/scoreboard_register_file_if.sv
// Bus bundle between decode/writeback/hazard logic and the register file.
interface scoreboard_register_file_if #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD_PORTS*AW-1:0]   rs_addr;
  logic [NUM_RD_PORTS*XLEN-1:0] rs_dout;
  logic [NUM_RD_PORTS-1:0]      rs_busy;
  logic                         issue_valid;
  logic [AW-1:0]                issue_rd;
  logic                         issue_stall;
  logic                         wb_valid;
  logic [AW-1:0]                wb_rd;
  logic [XLEN-1:0]              wb_din;
  logic [XLEN-1:0]              dbg_reg;
  logic [NUM_REGS*XLEN-1:0]     print_reg;

  modport master (
    output rs_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_din,
    input  rs_dout, rs_busy, issue_stall, dbg_reg, print_reg
  );

  modport slave (
    input  rs_addr, issue_valid, issue_rd, wb_valid, wb_rd, wb_din,
    output rs_dout, rs_busy, issue_stall, dbg_reg, print_reg
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue marks a destination busy, writeback retires it.
// Produces the WAW issue stall and the raw per-read-port busy lookup.
module rf_scoreboard #(
  parameter int NUM_REGS     = rf_pkg::NUM_REGS,
  parameter int NUM_RD_PORTS = rf_pkg::NUM_RD_PORTS
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0]            issue_rd,
  input  logic                                   wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]            wb_rd,
  input  logic [NUM_RD_PORTS*$clog2(NUM_REGS)-1:0] rs_addr,
  output logic                                   issue_stall,
  output logic [NUM_RD_PORTS-1:0]                rs_busy
);
  import rf_pkg::*;

  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wb_hit;
  logic                issue_hit;

  // Stall a second writer unless the current one retires this very cycle
  always_comb begin
    issue_stall = issue_valid && (issue_rd != AW'(REG_X0)) && busy[issue_rd]
                  && !(wb_valid && (wb_rd == issue_rd));
  end

  // Next busy vector: retire first, then a new accepted issue overrides (new producer wins)
  always_comb begin
    busy_nxt  = busy;
    wb_hit    = wb_valid && (wb_rd != AW'(REG_X0));
    issue_hit = issue_valid && !issue_stall && (issue_rd != AW'(REG_X0));
    if (wb_hit)    busy_nxt[wb_rd]    = 1'b0;
    if (issue_hit) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[REG_X0] = 1'b0;
  end

  // Busy state register
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Busy lookup for each read port
  always_comb begin
    rs_busy = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rs_busy[p] = busy[rs_addr[p*AW +: AW]];
    end
  end
endmodule

// File: rtl/scoreboard_register_file.sv
// Integer register file with asynchronous read ports, one writeback port and
// a busy scoreboard. Optional macro RF_WB_BYPASS_EN forwards same-cycle
// writeback data (and clears busy) on matching read ports.
module scoreboard_register_file #(
  parameter int              XLEN         = rf_pkg::XLEN,
  parameter int              NUM_REGS     = rf_pkg::NUM_REGS,
  parameter int              NUM_RD_PORTS = rf_pkg::NUM_RD_PORTS,
  parameter int              SP_IDX       = rf_pkg::REG_SP,
  parameter logic [XLEN-1:0] SP_INIT      = rf_pkg::SP_INIT_VAL,
  parameter int              DBG_IDX      = rf_pkg::DBG_REG_IDX
) (
  input logic                       clk,
  input logic                       reset,
  scoreboard_register_file_if.slave bus
);
  import rf_pkg::*;

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]         rf [NUM_REGS];
  logic [NUM_RD_PORTS-1:0] sb_busy;

  rf_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .wb_valid    (bus.wb_valid),
    .wb_rd       (bus.wb_rd),
    .rs_addr     (bus.rs_addr),
    .issue_stall (bus.issue_stall),
    .rs_busy     (sb_busy)
  );

  // Data array: reset loads zeros plus the stack pointer; x0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (bus.wb_valid && (bus.wb_rd != AW'(REG_X0))) begin
      rf[bus.wb_rd] <= bus.wb_din;
    end
  end

  // Read muxes, with optional write-first forwarding from writeback
  always_comb begin
    bus.rs_dout = '0;
    bus.rs_busy = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      bus.rs_dout[p*XLEN +: XLEN] = rf[bus.rs_addr[p*AW +: AW]];
      bus.rs_busy[p]              = sb_busy[p];
`ifdef RF_WB_BYPASS_EN
      if (bus.wb_valid && (bus.wb_rd != AW'(REG_X0)) &&
          (bus.wb_rd == bus.rs_addr[p*AW +: AW])) begin
        bus.rs_dout[p*XLEN +: XLEN] = bus.wb_din;
        bus.rs_busy[p]              = 1'b0;
      end
`endif
    end
  end

  // Un-bypassed debug views of the array
  always_comb begin
    bus.dbg_reg = rf[DBG_IDX];
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.print_reg[i*XLEN +: XLEN] = rf[i];
    end
  end
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Self-checking bench for scoreboard_register_file (directed scenarios plus
// randomized traffic against an array/flag reference model).
module tb_scoreboard_register_file;
  import rf_pkg::*;

  localparam int NP = NUM_RD_PORTS;
  localparam int AW = REG_AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  scoreboard_register_file_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD_PORTS(NP)) bus ();

  scoreboard_register_file #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD_PORTS(NP),
    .SP_IDX(2), .SP_INIT(32'h2ffc), .DBG_IDX(17)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents and "has an unretired producer" flags
  logic [XLEN-1:0] m_rf   [NUM_REGS];
  bit              m_busy [NUM_REGS];

  function automatic bit model_stall();
    int d;
    d = int'(bus.issue_rd);
    if (!bus.issue_valid || d == 0) return 1'b0;
    if (bus.wb_valid && int'(bus.wb_rd) == d) return 1'b0;
    return m_busy[d];
  endfunction

  function automatic logic [XLEN-1:0] exp_dout(int a);
`ifdef RF_WB_BYPASS_EN
    if (bus.wb_valid && bus.wb_rd != 0 && int'(bus.wb_rd) == a) return bus.wb_din;
`endif
    return (a == 0) ? '0 : m_rf[a];
  endfunction

  function automatic bit exp_busy(int a);
`ifdef RF_WB_BYPASS_EN
    if (bus.wb_valid && bus.wb_rd != 0 && int'(bus.wb_rd) == a) return 1'b0;
`endif
    return (a == 0) ? 1'b0 : m_busy[a];
  endfunction

  // Advance one clock, updating the model from the inputs presented this cycle
  task automatic tick();
    bit st;
    st = model_stall();
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        m_rf[i]   = (i == 2) ? 32'h2ffc : '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (bus.wb_valid && bus.wb_rd != 0) begin
        m_rf[bus.wb_rd]   = bus.wb_din;
        m_busy[bus.wb_rd] = 1'b0;
      end
      if (bus.issue_valid && !st && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit iv, int ird, bit wv, int wrd, logic [XLEN-1:0] din);
    bus.issue_valid = iv;
    bus.issue_rd    = AW'(ird);
    bus.wb_valid    = wv;
    bus.wb_rd       = AW'(wrd);
    bus.wb_din      = din;
  endtask

  task automatic set_addr(int p, int a);
    bus.rs_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] e;
    reset = 1'b1;
    drive(0, 0, 0, 0, '0);
    bus.rs_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    set_addr(0, 2);
    set_addr(1, 2);
    #1;
    for (int i = 0; i < NUM_REGS; i++) begin
      e = (i == 2) ? 32'h2ffc : '0;
      n_checks++;
      if (bus.print_reg[i*XLEN +: XLEN] !== e) begin
        n_fail++;
        $display("FAIL reset_rf[%0d]: got %h expected %h", i, bus.print_reg[i*XLEN +: XLEN], e);
      end
    end
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (bus.rs_dout[p*XLEN +: XLEN] !== 32'h2ffc || bus.rs_busy[p] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read_sp p%0d: got %h busy %b expected 00002ffc busy 0",
                 p, bus.rs_dout[p*XLEN +: XLEN], bus.rs_busy[p]);
      end
    end
    n_checks++;
    if (bus.issue_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b expected 0", bus.issue_stall);
    end
  endtask

  task automatic test_write();
    drive(0, 0, 1, 5, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, '0);
    set_addr(0, 5);
    set_addr(1, 5);
    #1;
    for (int p = 0; p < NP; p++) begin
      n_checks++;
      if (bus.rs_dout[p*XLEN +: XLEN] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL write_x5 p%0d: got %h expected deadbeef", p, bus.rs_dout[p*XLEN +: XLEN]);
      end
    end
    drive(1, 0, 1, 0, 32'h1234);
    tick();
    drive(0, 0, 0, 0, '0);
    set_addr(0, 0);
    #1;
    n_checks++;
    if (bus.rs_dout[0 +: XLEN] !== '0 || bus.rs_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL write_x0: got %h busy %b expected 0 busy 0", bus.rs_dout[0 +: XLEN], bus.rs_busy[0]);
    end
  endtask

  task automatic test_issue_stall();
    drive(1, 7, 0, 0, '0);
    tick();
    drive(0, 0, 0, 0, '0);
    set_addr(0, 7);
    #1;
    n_checks++;
    if (bus.rs_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_busy_x7: got %b expected 1", bus.rs_busy[0]);
    end
    drive(1, 7, 0, 0, '0);
    #1;
    n_checks++;
    if (bus.issue_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_stall_x7: got %b expected 1", bus.issue_stall);
    end
    tick();
    drive(0, 0, 0, 0, '0);
    #1;
    n_checks++;
    if (bus.rs_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL stalled_busy_x7: got %b expected 1", bus.rs_busy[0]);
    end
    drive(0, 0, 1, 7, 32'h55);
    tick();
    drive(0, 0, 0, 0, '0);
    #1;
    n_checks++;
    if (bus.rs_busy[0] !== 1'b0 || bus.rs_dout[0 +: XLEN] !== 32'h55) begin
      n_fail++;
      $display("FAIL retire_x7: got %h busy %b expected 00000055 busy 0",
               bus.rs_dout[0 +: XLEN], bus.rs_busy[0]);
    end
  endtask

  task automatic test_same_cycle();
    drive(1, 9, 0, 0, '0);
    tick();
    drive(1, 9, 1, 9, 32'h99);
    #1;
    n_checks++;
    if (bus.issue_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_stall_x9: got %b expected 0", bus.issue_stall);
    end
    tick();
    drive(0, 0, 0, 0, '0);
    set_addr(1, 9);
    #1;
    n_checks++;
    if (bus.rs_busy[1] !== 1'b1 || bus.print_reg[9*XLEN +: XLEN] !== 32'h99) begin
      n_fail++;
      $display("FAIL same_cycle_x9: got rf %h busy %b expected 00000099 busy 1",
               bus.print_reg[9*XLEN +: XLEN], bus.rs_busy[1]);
    end
    drive(0, 0, 1, 9, 32'h99);
    tick();
    drive(0, 0, 0, 0, '0);
  endtask

  task automatic test_bypass();
    drive(1, 3, 0, 0, '0);
    tick();
    drive(0, 0, 1, 3, 32'hA5A5);
    set_addr(0, 3);
    #1;
    n_checks++;
`ifdef RF_WB_BYPASS_EN
    if (bus.rs_dout[0 +: XLEN] !== 32'hA5A5 || bus.rs_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_x3: got %h busy %b expected 0000a5a5 busy 0",
               bus.rs_dout[0 +: XLEN], bus.rs_busy[0]);
    end
`else
    if (bus.rs_dout[0 +: XLEN] !== 32'h0 || bus.rs_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL nobypass_x3: got %h busy %b expected 00000000 busy 1",
               bus.rs_dout[0 +: XLEN], bus.rs_busy[0]);
    end
`endif
    n_checks++;
    if (bus.dbg_reg !== m_rf[17] || bus.print_reg[3*XLEN +: XLEN] !== 32'h0) begin
      n_fail++;
      $display("FAIL unbypassed_view: got dbg %h rf3 %h expected %h 00000000",
               bus.dbg_reg, bus.print_reg[3*XLEN +: XLEN], m_rf[17]);
    end
    tick();
    drive(0, 0, 0, 0, '0);
    #1;
    n_checks++;
    if (bus.rs_dout[0 +: XLEN] !== 32'hA5A5 || bus.rs_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL after_wb_x3: got %h busy %b expected 0000a5a5 busy 0",
               bus.rs_dout[0 +: XLEN], bus.rs_busy[0]);
    end
  endtask

  task automatic test_reset_midop();
    drive(1, 4, 0, 0, '0);
    tick();
    drive(1, 6, 1, 4, 32'h44);
    tick();
    drive(1, 4, 0, 0, '0);
    tick();
    reset = 1'b1;
    drive(1, 8, 1, 4, 32'h77);
    tick();
    reset = 1'b0;
    drive(1, 4, 0, 0, '0);
    set_addr(0, 4);
    set_addr(1, 6);
    #1;
    n_checks++;
    if (bus.rs_busy !== 2'b00 || bus.rs_dout[0 +: XLEN] !== 32'h0 || bus.issue_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got busy %b x4 %h stall %b expected busy 00 x4 00000000 stall 0",
               bus.rs_busy, bus.rs_dout[0 +: XLEN], bus.issue_stall);
    end
    n_checks++;
    if (bus.print_reg[2*XLEN +: XLEN] !== 32'h2ffc || bus.print_reg[8*XLEN +: XLEN] !== 32'h0) begin
      n_fail++;
      $display("FAIL midop_reset_rf: got x2 %h x8 %h expected 00002ffc 00000000",
               bus.print_reg[2*XLEN +: XLEN], bus.print_reg[8*XLEN +: XLEN]);
    end
    drive(0, 0, 0, 0, '0);
  endtask

  function automatic int pick_reg();
    return ($urandom_range(0, 4) == 0) ? 17 : int'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [NUM_REGS*XLEN-1:0] img;
    int a;
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 1) == 1, pick_reg(), $urandom_range(0, 2) != 0, pick_reg(), $urandom);
      for (int p = 0; p < NP; p++) set_addr(p, pick_reg());
      #1;
      for (int p = 0; p < NP; p++) begin
        a = int'(bus.rs_addr[p*AW +: AW]);
        n_checks++;
        if (bus.rs_dout[p*XLEN +: XLEN] !== exp_dout(a) || bus.rs_busy[p] !== exp_busy(a)) begin
          n_fail++;
          $display("FAIL rand_read c%0d p%0d x%0d: got %h busy %b expected %h busy %b",
                   c, p, a, bus.rs_dout[p*XLEN +: XLEN], bus.rs_busy[p], exp_dout(a), exp_busy(a));
        end
      end
      n_checks++;
      if (bus.issue_stall !== model_stall()) begin
        n_fail++;
        $display("FAIL rand_stall c%0d: got %b expected %b", c, bus.issue_stall, model_stall());
      end
      for (int i = 0; i < NUM_REGS; i++) img[i*XLEN +: XLEN] = m_rf[i];
      n_checks++;
      if (bus.print_reg !== img || bus.dbg_reg !== m_rf[17]) begin
        n_fail++;
        $display("FAIL rand_image c%0d: got dbg %h expected %h (image differs: %b)",
                 c, bus.dbg_reg, m_rf[17], bus.print_reg !== img);
      end
      tick();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, '0);
  endtask

  initial begin
    drive(0, 0, 0, 0, '0);
    bus.rs_addr = '0;
    test_reset();
    test_write();
    test_issue_stall();
    test_same_cycle();
    test_bypass();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
